// File: rtl/safe.sv
// safe: keypad safe controller (ports: clk, reset_n, row1-4, col1-3, reset_password, initialize -> password_led, state)
module safe (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       row1,
  input  logic       row2,
  input  logic       row3,
  input  logic       row4,
  input  logic       col1,
  input  logic       col2,
  input  logic       col3,
  input  logic       reset_password,
  input  logic       initialize,
  output logic [5:0] password_led,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    OFF    = 3'b000,
    ON     = 3'b001,
    WRONG1 = 3'b010,
    WRONG2 = 3'b011,
    OPEN   = 3'b100,
    CHANGE = 3'b101,
    BAD    = 3'b110,
    LOCK   = 3'b111
  } state_t;
  state_t st, st_n;
  logic [5:0][3:0] ent, ent_n, pw, pw_n;
  logic [2:0] cnt, cnt_n, len, len_n;
  logic [11:0] pr, pr_n, rise;
  logic [3:0] rows, key, dig;
  logic [2:0] cols;
  logic one_row, ev, match, is_digit;
  assign rows = {row4, row3, row2, row1};
  assign cols = {col3, col2, col1};
  assign one_row = rows != 4'd0 && (rows & (rows - 4'd1)) == 4'd0;
  always_comb begin
    pr_n = pr;
    for (int r = 0; r < 4; r++)
      if (one_row && rows[r]) pr_n[3*r +: 3] = cols;
  end
  assign rise = pr_n & ~pr;
  assign ev = rise != 12'd0 && (rise & (rise - 12'd1)) == 12'd0;
  always_comb begin
    key = 4'd0;
    for (int k = 0; k < 12; k++)
      if (rise[k]) key = 4'(k);
  end
  assign is_digit = key != 4'd9 && key != 4'd11;
  assign dig = key < 4'd9 ? key + 4'd1 : 4'd0;
  always_comb begin
    match = cnt == len;
    for (int i = 0; i < 6; i++)
      if (3'(i) < cnt && ent[i] != pw[i]) match = 1'b0;
  end
  always_ff @(posedge clk)
    if (!reset_n || initialize) begin
      st <= OFF;
      ent <= '0;
      cnt <= '0;
      pw <= 24'h004321;
      len <= 3'd4;
      pr <= '0;
    end else begin
      st <= st_n;
      ent <= ent_n;
      cnt <= cnt_n;
      pw <= pw_n;
      len <= len_n;
      pr <= pr_n;
    end
  always_comb begin
    st_n = st;
    ent_n = ent;
    cnt_n = cnt;
    pw_n = pw;
    len_n = len;
    case (st)
      OFF: if (ev) begin
        st_n = ON;
        ent_n = '0;
        cnt_n = '0;
      end
      ON, WRONG1, WRONG2, CHANGE: if (ev) begin
        if (is_digit) begin
          if (cnt < 3'd6) begin
            ent_n[cnt] = dig;
            cnt_n = cnt + 3'd1;
          end
        end else if (key == 4'd9) begin
          ent_n = '0;
          cnt_n = '0;
        end else if (cnt != 3'd0) begin
          ent_n = '0;
          cnt_n = '0;
          if (st == CHANGE) begin
            pw_n = ent;
            len_n = cnt;
            st_n = OFF;
          end else
            st_n = match ? OPEN : st == ON ? WRONG1 : st == WRONG1 ? WRONG2 : LOCK;
        end
      end
      OPEN: if (reset_password) begin
        st_n = CHANGE;
        ent_n = '0;
        cnt_n = '0;
      end else if (ev && key == 4'd11) st_n = OFF;
      LOCK: st_n = LOCK;
      default: begin
        st_n = OFF;
        ent_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  assign state = st;
  assign password_led = {cnt >= 3'd1, cnt >= 3'd2, cnt >= 3'd3, cnt >= 3'd4, cnt >= 3'd5, cnt >= 3'd6};
endmodule

// File: tb/tb_safe.sv
// tb_safe: directed scoreboard bench for the keypad safe
module tb_safe;
  logic clk = 0, reset_n, initialize, reset_password;
  logic [3:0] rows;
  logic [2:0] cols;
  logic [5:0] password_led;
  logic [2:0] state;
  logic [8:0] exp_q[$];
  string tag_q[$];
  int checks = 0, errors = 0;
  safe dut (
    .clk(clk), .reset_n(reset_n),
    .row1(rows[0]), .row2(rows[1]), .row3(rows[2]), .row4(rows[3]),
    .col1(cols[0]), .col2(cols[1]), .col3(cols[2]),
    .reset_password(reset_password), .initialize(initialize),
    .password_led(password_led), .state(state)
  );
  always #5 clk = ~clk;
  task automatic want(logic [2:0] s, logic [5:0] l, string t);
    exp_q.push_back({s, l});
    tag_q.push_back(t);
  endtask
  task automatic cmp();
    logic [8:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert ({state, password_led} === e) else begin
      errors++;
      $error("FAIL %s: got state=%b led=%b expected state=%b led=%b", t, state, password_led, e[8:6], e[5:0]);
    end
  endtask
  // d: 0-9 digits, 10 = '*', 11 = '#'
  task automatic press(int d, logic [2:0] s, logic [5:0] l, string t);
    int k;
    k = d == 0 ? 10 : d < 10 ? d - 1 : d == 10 ? 9 : 11;
    rows = 4'(1 << (k / 3));
    cols = 3'(1 << (k % 3));
    want(s, l, t);
    @(posedge clk); #1;
    cmp();
    @(posedge clk); #1;
    cols = 0;
    repeat (2) @(posedge clk);
    #1 rows = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    rows = 0; cols = 0; reset_n = 0; initialize = 0; reset_password = 0;
    repeat (2) @(posedge clk);
    #1 want(3'b000, 6'b000000, "reset");
    cmp();
    reset_n = 1;
    press(5, 3'b001, 6'b000000, "off_to_on");
    press(1, 3'b001, 6'b100000, "d1");
    press(2, 3'b001, 6'b110000, "d2");
    press(3, 3'b001, 6'b111000, "d3");
    press(4, 3'b001, 6'b111100, "d4");
    press(11, 3'b100, 6'b000000, "open");
    press(5, 3'b100, 6'b000000, "open_digit_ignored");
    press(11, 3'b000, 6'b000000, "open_close");
    press(1, 3'b001, 6'b000000, "on_again");
    press(9, 3'b001, 6'b100000, "w9a");
    press(11, 3'b010, 6'b000000, "wrong1");
    press(9, 3'b010, 6'b100000, "w9b");
    press(11, 3'b011, 6'b000000, "wrong2");
    press(9, 3'b011, 6'b100000, "w9c");
    press(11, 3'b111, 6'b000000, "lock");
    press(1, 3'b111, 6'b000000, "lock_key");
    press(11, 3'b111, 6'b000000, "lock_hash");
    initialize = 1;
    want(3'b000, 6'b000000, "initialize");
    @(posedge clk); #1;
    cmp();
    initialize = 0;
    press(3, 3'b001, 6'b000000, "on3");
    press(1, 3'b001, 6'b100000, "e1");
    press(2, 3'b001, 6'b110000, "e2");
    press(3, 3'b001, 6'b111000, "e3");
    press(4, 3'b001, 6'b111100, "e4");
    press(11, 3'b100, 6'b000000, "open2");
    reset_password = 1;
    press(11, 3'b101, 6'b000000, "change_beats_key");
    reset_password = 0;
    press(7, 3'b101, 6'b100000, "c7a");
    press(7, 3'b101, 6'b110000, "c7b");
    press(11, 3'b000, 6'b000000, "stored");
    press(5, 3'b001, 6'b000000, "on4");
    press(7, 3'b001, 6'b100000, "n7a");
    press(7, 3'b001, 6'b110000, "n7b");
    press(11, 3'b100, 6'b000000, "new_pw_opens");
    press(11, 3'b000, 6'b000000, "close2");
    press(5, 3'b001, 6'b000000, "on5");
    press(1, 3'b001, 6'b100000, "o1");
    press(2, 3'b001, 6'b110000, "o2");
    press(3, 3'b001, 6'b111000, "o3");
    press(4, 3'b001, 6'b111100, "o4");
    press(11, 3'b010, 6'b000000, "old_pw_rejected");
    press(1, 3'b010, 6'b100000, "f1");
    press(2, 3'b010, 6'b110000, "f2");
    press(3, 3'b010, 6'b111000, "f3");
    press(4, 3'b010, 6'b111100, "f4");
    press(5, 3'b010, 6'b111110, "f5");
    press(6, 3'b010, 6'b111111, "f6");
    press(7, 3'b010, 6'b111111, "seventh_dropped");
    press(10, 3'b010, 6'b000000, "star_clear");
    press(11, 3'b010, 6'b000000, "hash_empty");
    // key 2 held: col2 high whenever row1 is strobed, across 10 scans
    want(3'b010, 6'b100000, "held_key_once");
    for (int s = 0; s < 10; s++)
      for (int r = 0; r < 4; r++) begin
        rows = 4'(1 << r);
        cols = r == 0 ? 3'b010 : 3'b000;
        repeat (2) @(posedge clk);
        #1;
      end
    cmp();
    rows = 4'b0001; cols = 0;
    repeat (2) @(posedge clk);
    #1 rows = 4'b0011; cols = 3'b001;
    want(3'b010, 6'b100000, "two_rows_no_event");
    repeat (3) @(posedge clk);
    #1 cmp();
    rows = 0; cols = 0;
    press(11, 3'b011, 6'b000000, "to_wrong2");
    press(1, 3'b011, 6'b100000, "g1");
    press(2, 3'b011, 6'b110000, "g2");
    press(3, 3'b011, 6'b111000, "g3");
    reset_n = 0;
    want(3'b000, 6'b000000, "reset_mid_entry");
    @(posedge clk); #1;
    cmp();
    reset_n = 1;
    press(5, 3'b001, 6'b000000, "on6");
    press(1, 3'b001, 6'b100000, "h1");
    press(2, 3'b001, 6'b110000, "h2");
    press(3, 3'b001, 6'b111000, "h3");
    press(4, 3'b001, 6'b111100, "h4");
    press(11, 3'b100, 6'b000000, "default_pw_restored");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
